// File: rtl/byte_access_port.sv
// Byte-addressed load/store front end for one port of the byte-enabled word RAM.
// Unaligned accesses that cross a word boundary are split into two word accesses.
module byte_access_port #(
    parameter int unsigned ADDRESS_BITWIDTH = 16,
    parameter int unsigned DATA_BITWIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [1:0]                  req_size,
    input  logic                        req_signed,
    input  logic [ADDRESS_BITWIDTH+1:0] req_address,
    input  logic [DATA_BITWIDTH-1:0]    req_data,
    output logic                        rsp_valid,
    output logic [DATA_BITWIDTH-1:0]    rsp_data,
    output logic [ADDRESS_BITWIDTH-1:0] ram_address,
    output logic [3:0]                  ram_write_enable,
    output logic [DATA_BITWIDTH-1:0]    ram_data_out,
    input  logic [DATA_BITWIDTH-1:0]    ram_data_in
);

    typedef enum logic [1:0] {StIdle, StRdLow, StRdHigh, StWrHigh} state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Lanes lo .. hi-1 set.
    function automatic logic [3:0] lane_mask(input logic [2:0] lo, input logic [2:0] hi);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[i] = (3'(i) >= lo) && (3'(i) < hi);
        end
        return m;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            2'd0:    extend = {{24{sgn & v[7]}}, v[7:0]};
            2'd1:    extend = {{16{sgn & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    state_e                      state_q, state_d;
    logic                        active_q;
    logic [ADDRESS_BITWIDTH-1:0] word_q;
    logic [1:0]                  off_q;
    logic [1:0]                  size_q;
    logic                        signed_q;
    logic                        span_q;
    logic [31:0]                 data_q, data_d;
    logic                        rsp_valid_d;
    logic [31:0]                 rsp_data_d;
    logic                        capture;

    logic [1:0]                  req_off;
    logic [ADDRESS_BITWIDTH-1:0] req_word;
    logic [2:0]                  req_end;
    logic                        req_span;
    logic [3:0]                  req_low_we;
    logic [4:0]                  req_shift;
    logic [5:0]                  req_rshift;
    logic [2:0]                  cur_end;
    logic [3:0]                  cur_high_we;
    logic [4:0]                  off_shift;
    logic [5:0]                  off_rshift;
    logic [ADDRESS_BITWIDTH-1:0] word_next;

    assign req_off     = req_address[1:0];
    assign req_word    = req_address[ADDRESS_BITWIDTH+1:2];
    assign req_end     = {1'b0, req_off} + size_bytes(req_size);
    assign req_span    = req_end > 3'd4;
    assign req_low_we  = lane_mask({1'b0, req_off}, req_span ? 3'd4 : req_end);
    assign req_shift   = {req_off, 3'b000};
    assign req_rshift  = 6'd32 - {1'b0, req_off, 3'b000};

    assign cur_end     = {1'b0, off_q} + size_bytes(size_q);
    assign cur_high_we = lane_mask(3'd0, cur_end - 3'd4);
    assign off_shift   = {off_q, 3'b000};
    assign off_rshift  = 6'd32 - {1'b0, off_q, 3'b000};
    assign word_next   = word_q + ADDRESS_BITWIDTH'(1);

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        ram_address      = '0;
        ram_write_enable = '0;
        ram_data_out     = '0;
        data_d           = data_q;
        rsp_valid_d      = 1'b0;
        rsp_data_d       = rsp_data;
        capture          = 1'b0;
        // Outputs stay quiet until the first clock edge after reset release.
        if (active_q) begin
            unique case (state_q)
                StIdle: begin
                    req_ready    = 1'b1;
                    ram_address  = req_word;
                    ram_data_out = req_data << req_shift;
                    if (req_valid) begin
                        capture = 1'b1;
                        if (req_write) begin
                            ram_write_enable = req_low_we;
                            data_d           = req_data >> req_rshift;
                            if (req_span) begin
                                state_d = StWrHigh;
                            end else begin
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = '0;
                            end
                        end else begin
                            state_d = StRdLow;
                        end
                    end
                end
                StRdLow: begin
                    ram_address = span_q ? word_next : word_q;
                    if (span_q) begin
                        data_d  = ram_data_in >> off_shift;
                        state_d = StRdHigh;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = extend(ram_data_in >> off_shift, size_q, signed_q);
                        state_d     = StIdle;
                    end
                end
                StRdHigh: begin
                    ram_address = word_next;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = extend(data_q | (ram_data_in << off_rshift), size_q, signed_q);
                    state_d     = StIdle;
                end
                StWrHigh: begin
                    ram_address      = word_next;
                    ram_write_enable = cur_high_we;
                    ram_data_out     = data_q;
                    rsp_valid_d      = 1'b1;
                    rsp_data_d       = '0;
                    state_d          = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            active_q  <= 1'b0;
            word_q    <= '0;
            off_q     <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            span_q    <= 1'b0;
            data_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= 1'b1;
            data_q    <= data_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            if (capture) begin
                word_q   <= req_word;
                off_q    <= req_off;
                size_q   <= req_size;
                signed_q <= req_signed;
                span_q   <= req_span;
            end
        end
    end

endmodule

// File: tb/tb_byte_access_port.sv
// Self-checking bench for byte_access_port: directed vectors, reset corner cases and
// random traffic against a byte-array memory model.
module tb_byte_access_port;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW+1:0] req_address;
    logic [31:0]   req_data;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_write_enable;
    logic [31:0]   ram_data_out;
    logic [31:0]   ram_data_in;

    always #5 clk = ~clk;

    byte_access_port #(
        .ADDRESS_BITWIDTH(AW),
        .DATA_BITWIDTH   (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_address     (req_address),
        .req_data        (req_data),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .ram_address     (ram_address),
        .ram_write_enable(ram_write_enable),
        .ram_data_out    (ram_data_out),
        .ram_data_in     (ram_data_in)
    );

    // Byte-enabled RAM with one-cycle read latency.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_write_enable[i]) mem[ram_address][8*i +: 8] <= ram_data_out[8*i +: 8];
        end
        ram_data_in <= mem[ram_address];
    end

    // Reference model: flat little-endian byte memory.
    logic [7:0] ref_mem [64];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] a, input logic [1:0] sz,
                                             input logic sg);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(int'(a) + k) % 64];
        if (sg && n == 1 && v[7]) v[31:8] = '1;
        if (sg && n == 2 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    task automatic ref_store(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int k = 0; k < nbytes(sz); k++) ref_mem[(int'(a) + k) % 64] = d[8*k +: 8];
    endtask

    function automatic int ref_lat(input logic w, input logic [1:0] sz, input logic [5:0] a);
        int span;
        span = ((int'(a) % 4) + nbytes(sz) > 4) ? 1 : 0;
        return (w ? 1 : 2) + span;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [AW-1:0] t0_addr, t1_addr;
    logic [3:0]    t0_we, t1_we;
    logic [31:0]   t0_dout, t1_dout;

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [5:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
        logic busy_ok;
        req_valid   = 1'b1;
        req_write   = w;
        req_size    = sz;
        req_signed  = sg;
        req_address = a;
        req_data    = d;
        #1;
        t0_addr = ram_address;
        t0_we   = ram_write_enable;
        t0_dout = ram_data_out;
        check("ready_idle", 32'(req_ready), 32'd1);
        lat     = 0;
        busy_ok = 1'b1;
        rd      = 'x;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                t1_addr     = ram_address;
                t1_we       = ram_write_enable;
                t1_dout     = ram_data_out;
                req_valid   = 1'b0;
                req_write   = 1'($urandom);
                req_size    = 2'($urandom);
                req_signed  = 1'($urandom);
                req_address = 6'($urandom);
                req_data    = $urandom;
            end
            if (rsp_valid) begin
                lat = cyc;
                rd  = rsp_data;
                break;
            end
            if (req_ready) busy_ok = 1'b0;
        end
        check("ready_low_busy", 32'(busy_ok), 32'd1);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        w, sg;
        logic [1:0]  sz;
        logic [5:0]  a;
        logic [31:0] d, exp;

        tbl[0] = '{1'b1, 2'd2, 1'b0, 6'h10, 32'hDEADBEEF, 32'h0,        1};
        tbl[1] = '{1'b0, 2'd2, 1'b0, 6'h10, 32'h0,        32'hDEADBEEF, 2};
        tbl[2] = '{1'b0, 2'd0, 1'b1, 6'h13, 32'h0,        32'hFFFFFFDE, 2};
        tbl[3] = '{1'b0, 2'd0, 1'b0, 6'h13, 32'h0,        32'h000000DE, 2};
        tbl[4] = '{1'b0, 2'd1, 1'b1, 6'h12, 32'h0,        32'hFFFFDEAD, 2};
        tbl[5] = '{1'b1, 2'd1, 1'b0, 6'h17, 32'h0000A55A, 32'h0,        2};
        tbl[6] = '{1'b0, 2'd1, 1'b0, 6'h17, 32'h0,        32'h0000A55A, 3};
        tbl[7] = '{1'b1, 2'd2, 1'b0, 6'h3F, 32'h11223344, 32'h0,        2};
        tbl[8] = '{1'b0, 2'd2, 1'b0, 6'h3F, 32'h0,        32'h11223344, 3};

        // Reset with a store request pending: everything must stay quiet.
        rst_n       = 1'b0;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_size    = 2'd2;
        req_signed  = 1'b0;
        req_address = 6'h3F;
        req_data    = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_we", 32'(ram_write_enable), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_dout", ram_data_out, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #1;
        check("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_edge", 32'(req_ready), 32'd1);

        // Directed vectors; consecutive calls are accepted in the prior response cycle.
        for (int i = 0; i < 9; i++) begin
            do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d, rd, lat);
            if (tbl[i].w) ref_store(tbl[i].a, tbl[i].sz, tbl[i].d);
            check($sformatf("vec%0d_data", i), rd, tbl[i].exp);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            if (i == 0) begin
                check("st_word_addr", 32'(t0_addr), 32'd4);
                check("st_word_we", 32'(t0_we), 32'hF);
                check("st_word_dout", t0_dout, 32'hDEADBEEF);
            end
            if (i == 5) begin
                check("st_half_t0_addr", 32'(t0_addr), 32'd5);
                check("st_half_t0_we", 32'(t0_we), 32'h8);
                check("st_half_t0_lane3", 32'(t0_dout[31:24]), 32'h5A);
                check("st_half_t1_addr", 32'(t1_addr), 32'd6);
                check("st_half_t1_we", 32'(t1_we), 32'h1);
                check("st_half_t1_lane0", 32'(t1_dout[7:0]), 32'hA5);
            end
            if (i == 7) begin
                check("st_wrap_t0_addr", 32'(t0_addr), 32'd15);
                check("st_wrap_t0_we", 32'(t0_we), 32'h8);
                check("st_wrap_t0_lane3", 32'(t0_dout[31:24]), 32'h44);
                check("st_wrap_t1_addr", 32'(t1_addr), 32'd0);
                check("st_wrap_t1_we", 32'(t1_we), 32'h7);
                check("st_wrap_t1_low", 32'(t1_dout[23:0]), 32'h112233);
            end
        end
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("rsp_data_hold", rsp_data, 32'h11223344);

        // Reset in the second cycle of a spanning store.
        do_req(1'b1, 2'd2, 1'b0, 6'h20, 32'h55667788, rd, lat);
        ref_store(6'h20, 2'd2, 32'h55667788);
        do_req(1'b1, 2'd2, 1'b0, 6'h24, 32'h99AABBCC, rd, lat);
        ref_store(6'h24, 2'd2, 32'h99AABBCC);
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_size    = 2'd2;
        req_address = 6'h22;
        req_data    = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("wr_high_we", 32'(ram_write_enable), 32'h3);
        rst_n = 1'b0;
        #1;
        check("wr_abort_we", 32'(ram_write_enable), 32'd0);
        check("wr_abort_ready", 32'(req_ready), 32'd0);
        ref_mem[6'h22] = 8'h0D;
        ref_mem[6'h23] = 8'hF0;
        @(negedge clk);
        check("wr_abort_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_abort_rsp2", 32'(rsp_valid), 32'd0);
        check("wr_abort_ready_after", 32'(req_ready), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 6'h24, 32'h0, rd, lat);
        check("wr_abort_high_kept", rd, 32'h99AABBCC);
        do_req(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, rd, lat);
        check("wr_abort_low_written", rd, 32'hF00D7788);

        // Reset during a load: no response must appear.
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_size    = 2'd2;
        req_address = 6'h21;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rd_abort_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rd_abort_rsp2", 32'(rsp_valid), 32'd0);
        check("rd_abort_ready", 32'(req_ready), 32'd1);

        // Clear memory through the port, then random traffic against the model.
        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, 2'd2, 1'b0, 6'(i * 4), 32'h0, rd, lat);
            ref_store(6'(i * 4), 2'd2, 32'h0);
        end
        for (int i = 0; i < 200; i++) begin
            w   = 1'($urandom);
            sz  = 2'($urandom);
            sg  = 1'($urandom);
            a   = 6'($urandom);
            d   = $urandom;
            exp = w ? 32'h0 : ref_load(a, sz, sg);
            if ($urandom_range(3) == 0) @(negedge clk);
            do_req(w, sz, sg, a, d, rd, lat);
            if (w) ref_store(a, sz, d);
            check($sformatf("rnd%0d_data", i), rd, exp);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(w, sz, a)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_access_port.md
# byte_access_port

Initiator-side front end for the byte-enabled dual-port RAM. Accepts one byte-addressed load/store request at a time (byte, halfword or word, any alignment), converts it into one or two word-aligned RAM port accesses with per-byte write enables, and returns zero- or sign-extended load data. One instance drives one RAM port. The core load/store stage or the UART loader sits in front of it.

## Interface
Parameters:
- ADDRESS_BITWIDTH, 16, RAM word-address width; byte address is ADDRESS_BITWIDTH+2 bits
- DATA_BITWIDTH, 32, RAM word width (fixed 32, 4 byte lanes)

Ports:
- clk  in  1  clock; one clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 halfword, 2 word; 3 treated as word
- req_signed  in  1  loads: sign-extend; ignored for stores
- req_address  in  ADDRESS_BITWIDTH+2  byte address, little-endian
- req_data  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle pulse: load data valid / store complete
- rsp_data  out  32  load result; 0 for stores
- ram_address  out  ADDRESS_BITWIDTH  to RAM port address
- ram_write_enable  out  4  to RAM port write_enable; bit i = byte lane i (bits 8i+7:8i)
- ram_data_out  out  32  to RAM port data_in
- ram_data_in  in  32  from RAM port data_out (one-cycle read latency)

## Operation
- Byte offset o = req_address[1:0], word w = req_address[ADDRESS_BITWIDTH+1:2], byte count n = 1/2/4.
- Spanning access: o + n > 4. Needs a second access at w+1 (modulo 2^ADDRESS_BITWIDTH; top word wraps to 0).
- States: IDLE, RD_LOW, RD_HIGH, WR_HIGH.
- IDLE: req_ready = 1. ram_address = w combinationally from request; ram_write_enable = 0 unless accepting a store.
  - Accepted store: ram_write_enable = low-word lane mask (lanes o..min(o+n,4)-1), ram_data_out = req_data << 8o. Not spanning -> IDLE, rsp_valid next cycle. Spanning -> WR_HIGH.
  - Accepted load: ram_write_enable = 0 -> RD_LOW.
- RD_LOW: ram_data_in holds word w. Not spanning: extract, extend, register rsp_data, pulse rsp_valid, -> IDLE. Spanning: latch lanes o..3, drive ram_address = w+1 -> RD_HIGH.
- RD_HIGH: ram_data_in holds word w+1; merge lanes 0..(o+n-5) above latched bytes, extend, pulse rsp_valid, -> IDLE.
- WR_HIGH: ram_address = w+1 (registered), ram_write_enable = lanes 0..(o+n-5), ram_data_out = remaining bytes right-justified; pulse rsp_valid next cycle, -> IDLE.
- Extension: size byte/half, req_signed=1 -> replicate bit 7/15; else zero-fill. Word ignores req_signed.
- Request fields captured at acceptance; changes on req_* after acceptance have no effect.
- req_ready = 0 in RD_LOW, RD_HIGH, WR_HIGH; ram_write_enable = 0 in RD_LOW, RD_HIGH.

## Timing
- Acceptance in cycle T (req_valid && req_ready).
- Store, not spanning: RAM written at end of T; rsp_valid high in T+1.
- Store, spanning: low part written end of T, high part end of T+1; rsp_valid in T+2.
- Load, not spanning: rsp_valid and rsp_data in T+2.
- Load, spanning: rsp_valid in T+3.
- rsp_valid is exactly one cycle; rsp_data holds until next response.
- Back-to-back: state is IDLE during the rsp_valid cycle, so a new request may be accepted in that same cycle.
- Reset (rst_n low, any time): state IDLE, req_ready = 0, rsp_valid = 0, rsp_data = 0, ram_write_enable = 0, ram_address = 0, ram_data_out = 0. req_ready = 1 from the first clock edge after rst_n rises.
- Reset mid-spanning-store: high part aborted; low part already written stays. Reset mid-load: no response.

## Test plan
- Reset, then word store 0xDEADBEEF at byte 0x10 -> ram_address 4, ram_write_enable 4'b1111, rsp_valid in T+1; word load 0x10 -> rsp_data 0xDEADBEEF in T+2.
- Byte load 0x13, signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; halfword signed load 0x12 -> 0xFFFFDEAD.
- Halfword store 0xA55A at 0x17 -> T: addr 5, we 4'b1000, data lane3 0x5A; T+1: addr 6, we 4'b0001, lane0 0xA5; rsp_valid T+2. Unsigned halfword load 0x17 -> 0x0000A55A in T+3.
- Word store 0x11223344 at last byte address (ADDRESS_BITWIDTH=4: 0x3F) -> we 4'b1000 at word 15, we 4'b0111 at word 0 (wrap); load back equals 0x11223344.
- Back-to-back: store accepted in the cycle rsp_valid pulses for prior load; both complete, no dropped request, req_ready never high in a non-IDLE state.
- rst_n asserted in WR_HIGH -> ram_write_enable 0 immediately, no rsp_valid, req_ready 1 after release; word w+1 unchanged.
